ss2_cobs_rx: RTL and testbench

SS2_COBS_RX -- requirements
Module: ss2_cobs_rx

---
 rtl/ss2_cobs_rx.sv | 141 ++++++++++++++
 tb/tb_ss2_cobs_rx.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ss2_cobs_rx.sv
// COBS frame receiver: decodes UART bytes, parses cmd/scmd/dlen/payload/crc
// fields and reports one status code per frame on frame_done.
//
// Handshake: rx_valid, pl_valid, crc_data_en, crc_init and frame_done are
// single-cycle strobes with no back-pressure; each data bus is meaningful
// only in the cycle its strobe is high, and nothing waits on a ready.
module ss2_cobs_rx #(
  parameter int MAX_DLEN = 249
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic [7:0] crc_value,
  output logic [7:0] cmd,
  output logic [7:0] scmd,
  output logic [7:0] dlen,
  output logic [7:0] pl_data,
  output logic       pl_valid,
  output logic       crc_init,
  output logic [7:0] crc_data,
  output logic       crc_data_en,
  output logic       frame_done,
  output logic [2:0] frame_status,
  output logic       busy,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_SCMD, S_LEN, S_DATA, S_CRC, S_END, S_DISCARD
  } state_t;

  localparam logic [7:0] MAX_D = 8'(MAX_DLEN);

  state_t     state;
  logic [7:0] cnt;
  logic [7:0] data_left;
  logic [7:0] crc_byte;
  logic [2:0] err;
  logic [7:0] dec_byte;

  // A code byte arriving when the current block is exhausted stands for a zero.
  assign dec_byte  = (cnt == 8'd1) ? 8'h00 : rx_data;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      cnt          <= 8'd0;
      data_left    <= 8'd0;
      crc_byte     <= 8'd0;
      err          <= 3'd0;
      cmd          <= 8'd0;
      scmd         <= 8'd0;
      dlen         <= 8'd0;
      pl_data      <= 8'd0;
      pl_valid     <= 1'b0;
      crc_init     <= 1'b0;
      crc_data     <= 8'd0;
      crc_data_en  <= 1'b0;
      frame_done   <= 1'b0;
      frame_status <= 3'd0;
      busy         <= 1'b0;
    end else begin
      pl_valid    <= 1'b0;
      crc_init    <= 1'b0;
      crc_data_en <= 1'b0;
      frame_done  <= 1'b0;
      if (rx_valid) begin
        if (rx_data == 8'h00) begin
          // Empty frames (delimiter while idle) are silently dropped.
          if (state != S_IDLE) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= S_IDLE;
            cnt        <= 8'd0;
            err        <= 3'd0;
            if (err != 3'd0)              frame_status <= err;
            else if (cnt != 8'd1)         frame_status <= 3'd2;
            else if (state != S_END)      frame_status <= 3'd3;
            else if (crc_byte != crc_value) frame_status <= 3'd1;
            else                          frame_status <= 3'd0;
          end
        end else if (state == S_IDLE) begin
          cnt      <= rx_data;
          crc_init <= 1'b1;
          busy     <= 1'b1;
          state    <= S_CMD;
        end else begin
          cnt <= (cnt == 8'd1) ? rx_data : cnt - 8'd1;
          case (state)
            S_CMD: begin
              cmd         <= dec_byte;
              crc_data    <= dec_byte;
              crc_data_en <= 1'b1;
              state       <= S_SCMD;
            end
            S_SCMD: begin
              scmd        <= dec_byte;
              crc_data    <= dec_byte;
              crc_data_en <= 1'b1;
              state       <= S_LEN;
            end
            S_LEN: begin
              dlen        <= dec_byte;
              crc_data    <= dec_byte;
              crc_data_en <= 1'b1;
              data_left   <= dec_byte;
              if (dec_byte > MAX_D) begin
                err   <= 3'd4;
                state <= S_DISCARD;
              end else if (dec_byte == 8'd0) begin
                state <= S_CRC;
              end else begin
                state <= S_DATA;
              end
            end
            S_DATA: begin
              pl_data     <= dec_byte;
              pl_valid    <= 1'b1;
              crc_data    <= dec_byte;
              crc_data_en <= 1'b1;
              data_left   <= data_left - 8'd1;
              if (data_left == 8'd1) state <= S_CRC;
            end
            S_CRC: begin
              crc_byte <= dec_byte;
              state    <= S_END;
            end
            S_END: begin
              err   <= 3'd3;
              state <= S_DISCARD;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ss2_cobs_rx.sv
// Directed bench for ss2_cobs_rx: a frame-level model predicts every output
// cycle by cycle, and literal expectations pin each directed frame.
module tb_ss2_cobs_rx;

  localparam logic [7:0] MAX_D = 8'd4;
  localparam logic [7:0] CRC_V = 8'h5A;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] crc_value;
  logic [7:0] cmd, scmd, dlen, pl_data, crc_data;
  logic       pl_valid, crc_init, crc_data_en, frame_done, busy;
  logic [2:0] frame_status, dbg_state;

  assign crc_value = CRC_V;

  ss2_cobs_rx #(.MAX_DLEN(4)) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .crc_value(crc_value), .cmd(cmd), .scmd(scmd), .dlen(dlen),
    .pl_data(pl_data), .pl_valid(pl_valid), .crc_init(crc_init),
    .crc_data(crc_data), .crc_data_en(crc_data_en), .frame_done(frame_done),
    .frame_status(frame_status), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected finish before it");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    int         cyc;
    logic       init;
    logic       cen;
    logic [7:0] cdat;
    logic       plv;
    logic       done;
    logic [2:0] st;
    logic [7:0] cmd;
    logic [7:0] scmd;
    logic [7:0] dlen;
    logic       busy;
  } rec_t;

  rec_t       pend_q[$];
  rec_t       rec_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] crc_seen[$];

  int n_tests = 0;
  int n_fail  = 0;
  int n_pl = 0, n_done = 0;
  logic [7:0] last_pl = 8'h00;
  logic [7:0] m_cmd = 8'h00, m_scmd = 8'h00, m_dlen = 8'h00;
  logic [2:0] m_st = 3'd0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- frame-level model ----------------
  // COBS blocks are located by position: a code c at index p puts the next code
  // at p+c, and every code after the first decodes to a 0x00. Decoded bytes are
  // then split by index into cmd, scmd, dlen, dlen payload bytes and the crc.
  task automatic model_frame(input logic [7:0] fr[$]);
    rec_t       r;
    int         next_code, j, dl;
    logic [2:0] err, st;
    logic [7:0] crcb, d;
    next_code = 0; j = 0; dl = -1; err = 3'd0; crcb = 8'h00;
    foreach (fr[i]) begin
      r = '0;
      if (fr[i] != 8'h00 && i == 0) begin
        r.init = 1'b1;
        r.busy = 1'b1;
        next_code = int'(fr[i]);
      end else if (fr[i] != 8'h00) begin
        r.busy = 1'b1;
        if (i == next_code) begin
          d = 8'h00;
          next_code = i + int'(fr[i]);
        end else begin
          d = fr[i];
        end
        if (err == 3'd0) begin
          if (j <= 2) begin
            r.cen = 1'b1; r.cdat = d;
          end
          if (j == 0) m_cmd = d;
          else if (j == 1) m_scmd = d;
          else if (j == 2) begin
            m_dlen = d; dl = int'(d);
            if (d > MAX_D) err = 3'd4;
          end else if (j < dl + 3) begin
            r.cen = 1'b1; r.cdat = d; r.plv = 1'b1;
            exp_q.push_back(d);
          end else if (j == dl + 3) crcb = d;
          else err = 3'd3;
        end
        j++;
      end else if (i > 0) begin
        if (err != 3'd0)          st = err;
        else if (i != next_code)  st = 3'd2;
        else if (j != dl + 4)     st = 3'd3;
        else if (crcb != CRC_V)   st = 3'd1;
        else                      st = 3'd0;
        m_st   = st;
        r.done = 1'b1;
        r.busy = 1'b0;
      end
      r.cmd = m_cmd; r.scmd = m_scmd; r.dlen = m_dlen; r.st = m_st;
      pend_q.push_back(r);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_frame(input logic [7:0] fr[$]);
    rec_t r;
    model_frame(fr);
    foreach (fr[i]) begin
      @(posedge clk); #1;
      rx_data  = fr[i];
      rx_valid = 1'b1;
      r = pend_q.pop_front();
      r.cyc = cyc + 1;
      rec_q.push_back(r);
      @(posedge clk); #1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    m_cmd = 8'h00; m_scmd = 8'h00; m_dlen = 8'h00; m_st = 3'd0;
    rec_q.delete();
    repeat (2) @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  // ---------------- compare process ----------------
  logic [7:0] h_cmd = 8'h00, h_scmd = 8'h00, h_dlen = 8'h00;
  logic [2:0] h_st = 3'd0;
  logic       h_busy = 1'b0;

  always @(negedge clk) begin
    rec_t r;
    if (!reset_n) begin
      chk("rst_cmd", 32'(cmd), 0);            chk("rst_scmd", 32'(scmd), 0);
      chk("rst_dlen", 32'(dlen), 0);          chk("rst_pl_data", 32'(pl_data), 0);
      chk("rst_pl_valid", 32'(pl_valid), 0);  chk("rst_crc_init", 32'(crc_init), 0);
      chk("rst_crc_data", 32'(crc_data), 0);  chk("rst_crc_en", 32'(crc_data_en), 0);
      chk("rst_done", 32'(frame_done), 0);    chk("rst_status", 32'(frame_status), 0);
      chk("rst_busy", 32'(busy), 0);          chk("rst_state", 32'(dbg_state), 0);
      h_cmd = 8'h00; h_scmd = 8'h00; h_dlen = 8'h00; h_st = 3'd0; h_busy = 1'b0;
    end else begin
      if (rec_q.size() > 0 && rec_q[0].cyc == cyc) begin
        r = rec_q.pop_front();
      end else begin
        r = '0;
        r.cmd = h_cmd; r.scmd = h_scmd; r.dlen = h_dlen; r.st = h_st; r.busy = h_busy;
      end
      chk("crc_init", 32'(crc_init), 32'(r.init));
      chk("crc_data_en", 32'(crc_data_en), 32'(r.cen));
      chk("pl_valid", 32'(pl_valid), 32'(r.plv));
      chk("frame_done", 32'(frame_done), 32'(r.done));
      chk("frame_status", 32'(frame_status), 32'(r.st));
      chk("cmd", 32'(cmd), 32'(r.cmd));
      chk("scmd", 32'(scmd), 32'(r.scmd));
      chk("dlen", 32'(dlen), 32'(r.dlen));
      chk("busy", 32'(busy), 32'(r.busy));
      if (crc_data_en) begin
        chk("crc_data", 32'(crc_data), 32'(r.cdat));
        crc_seen.push_back(crc_data);
      end
      if (pl_valid) begin
        n_pl++;
        last_pl = pl_data;
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL pl_extra: got pl_valid=1 data %0h expected no payload", pl_data);
        end else begin
          chk("pl_data", 32'(pl_data), 32'(exp_q.pop_front()));
        end
      end
      if (frame_done) n_done++;
      h_cmd = r.cmd; h_scmd = r.scmd; h_dlen = r.dlen; h_st = r.st; h_busy = r.busy;
    end
  end

  // ---------------- directed stimulus ----------------
  logic [7:0] fr[$];
  int d0, p0;
  logic [31:0] crc_pack;

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // valid frame
    d0 = n_done; p0 = n_pl; crc_seen.delete();
    fr = '{8'h02, 8'h70, 8'h04, 8'h01, 8'hAB, 8'h5A, 8'h00};
    send_frame(fr);
    crc_pack = 32'h0;
    foreach (crc_seen[i]) crc_pack = {crc_pack[23:0], crc_seen[i]};
    chk("lit_ok_cmd", 32'(cmd), 32'h70);
    chk("lit_ok_scmd", 32'(scmd), 32'h00);
    chk("lit_ok_dlen", 32'(dlen), 32'h01);
    chk("lit_ok_status", 32'(frame_status), 0);
    chk("lit_ok_done_cnt", 32'(n_done - d0), 1);
    chk("lit_ok_pl_cnt", 32'(n_pl - p0), 1);
    chk("lit_ok_pl_data", 32'(last_pl), 32'hAB);
    chk("lit_ok_crc_cnt", 32'(crc_seen.size()), 4);
    chk("lit_ok_crc_seq", crc_pack, 32'h700001AB);

    // crc mismatch
    d0 = n_done; p0 = n_pl;
    fr = '{8'h02, 8'h70, 8'h04, 8'h01, 8'hAB, 8'h5B, 8'h00};
    send_frame(fr);
    chk("lit_crc_status", 32'(frame_status), 1);
    chk("lit_crc_pl_cnt", 32'(n_pl - p0), 1);
    chk("lit_crc_pl_data", 32'(last_pl), 32'hAB);

    // framing error
    fr = '{8'h05, 8'h70, 8'h01, 8'h00};
    send_frame(fr);
    chk("lit_cobs_status", 32'(frame_status), 2);

    // length error: delimiter while crc byte still expected
    fr = '{8'h02, 8'h70, 8'h03, 8'h01, 8'hAB, 8'h00};
    send_frame(fr);
    chk("lit_len_status", 32'(frame_status), 3);

    // dlen overflow
    p0 = n_pl;
    fr = '{8'h02, 8'h70, 8'h03, 8'h05, 8'h11, 8'h00};
    send_frame(fr);
    chk("lit_ovf_status", 32'(frame_status), 4);
    chk("lit_ovf_pl_cnt", 32'(n_pl - p0), 0);
    chk("lit_ovf_dlen", 32'(dlen), 32'h05);

    // lone delimiter is ignored
    d0 = n_done;
    fr = '{8'h00};
    send_frame(fr);
    chk("lit_empty_done_cnt", 32'(n_done - d0), 0);
    chk("lit_empty_busy", 32'(busy), 0);
    chk("lit_empty_status", 32'(frame_status), 4);

    // dlen = 0 goes straight to the crc byte
    p0 = n_pl;
    fr = '{8'h02, 8'h70, 8'h01, 8'h02, 8'h5A, 8'h00};
    send_frame(fr);
    chk("lit_zero_status", 32'(frame_status), 0);
    chk("lit_zero_dlen", 32'(dlen), 0);
    chk("lit_zero_pl_cnt", 32'(n_pl - p0), 0);

    // dlen = MAX_DLEN is accepted
    p0 = n_pl;
    fr = '{8'h02, 8'h70, 8'h07, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'h00};
    send_frame(fr);
    chk("lit_max_status", 32'(frame_status), 0);
    chk("lit_max_pl_cnt", 32'(n_pl - p0), 4);
    chk("lit_max_last_pl", 32'(last_pl), 32'h44);

    // extra decoded byte after the crc byte
    fr = '{8'h02, 8'h70, 8'h01, 8'h03, 8'h5A, 8'h33, 8'h00};
    send_frame(fr);
    chk("lit_end_status", 32'(frame_status), 3);

    // reset mid-frame, then a clean frame
    fr = '{8'h02, 8'h70};
    send_frame(fr);
    chk("lit_mid_busy", 32'(busy), 1);
    do_reset();
    @(negedge clk);
    chk("lit_rst_busy", 32'(busy), 0);
    chk("lit_rst_cmd", 32'(cmd), 0);
    d0 = n_done;
    fr = '{8'h02, 8'h70, 8'h04, 8'h01, 8'hAB, 8'h5A, 8'h00};
    send_frame(fr);
    chk("lit_rst_done_cnt", 32'(n_done - d0), 1);
    chk("lit_rst_status", 32'(frame_status), 0);

    repeat (3) @(posedge clk);
    chk("payload_left", 32'(exp_q.size()), 0);
    chk("records_left", 32'(rec_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
